// File: rtl/game_pkg.sv
// Shared constants for the game input path: button channel indices and debounce timing.
package game_pkg;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_FIRE  = 2;
  localparam int unsigned BTN_START = 3;

  // 5 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES = 500000;

  typedef enum logic {
    StStable,
    StPending
  } chan_st_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter and registered edge strobes.
module debounce_channel
  import game_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic rst,
  input  logic clk,
  input  logic raw,
  output logic press,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  chan_st_e         st;

  // State is the accepted level plus the counter; mismatch means a candidate level is pending.
  assign st = (sync2_q != press_q) ? StPending : StStable;

  always_comb begin
    cnt_d   = '0;
    press_d = press_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (st)
      StStable: cnt_d = '0;
      StPending: begin
        if (cnt_q == CntMax) begin
          press_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign press = press_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: one independent debounce_channel per button pin.
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  if (STABLE_CYCLES < 2) begin : g_bad_cfg
    $error("btn_debounce: STABLE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .rst  (rst),
      .clk  (clk),
      .raw  (btn_raw[i]),
      .press(press[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule
